// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM->WB payload bus with a valid/ready handshake.
//   valid/ready        : handshake; a transfer happens on a rising edge with both high
//   ctrl               : write-back control word
//   lane_mask          : 1 = lane active
//   valu / vmem        : per-lane vector ALU result / memory read data, lane 0 in LSBs
//   scalar / imm       : scalar ALU result / immediate
// The master drives the payload and valid; the slave drives ready.
interface mem_wb_stage_if #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
);
    logic                            valid;
    logic                            ready;
    logic [CTRL_W-1:0]               ctrl;
    logic [LANES-1:0]                lane_mask;
    logic [LANES-1:0][WIDTH-1:0]     valu;
    logic [LANES-1:0][WIDTH-1:0]     vmem;
    logic [WIDTH-1:0]                scalar;
    logic [WIDTH-1:0]                imm;

    modport master (output valid, ctrl, lane_mask, valu, vmem, scalar, imm, input ready);
    modport slave  (input valid, ctrl, lane_mask, valu, vmem, scalar, imm, output ready);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with a main + skid entry.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; empties both entries and zeroes payload
//   flush      : synchronous; kills both entries (wins over accept and delivery)
//   up         : upstream bus (slave); up.ready is a flop output
//   dn         : downstream bus (master); payload reads 0 while dn.valid is 0
//   stall_cnt  : saturating count of edges with dn.valid & !dn.ready
// Payload is captured with inactive lanes of valu/vmem forced to zero.

// Per-lane capture masking.
module mem_wb_lane #(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_valu,
    input  logic [WIDTH-1:0] i_vmem,
    output logic [WIDTH-1:0] o_valu,
    output logic [WIDTH-1:0] o_vmem
);
    assign o_valu = i_en ? i_valu : '0;
    assign o_vmem = i_en ? i_vmem : '0;
endmodule

module mem_wb_stage #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    mem_wb_stage_if.slave     up,
    mem_wb_stage_if.master    dn,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef struct packed {
        logic [CTRL_W-1:0]           ctrl;
        logic [LANES-1:0]            mask;
        logic [LANES-1:0][WIDTH-1:0] valu;
        logic [LANES-1:0][WIDTH-1:0] vmem;
        logic [WIDTH-1:0]            scalar;
        logic [WIDTH-1:0]            imm;
    } pld_t;

    logic                        r_main_vld;
    logic                        r_skid_vld;
    logic                        r_in_rdy;
    pld_t                        r_main;
    pld_t                        r_skid;
    logic [CNT_W-1:0]            r_stall;

    logic                        w_acc;
    logic                        w_dlv;
    pld_t                        w_cap;
    logic [LANES-1:0][WIDTH-1:0] w_valu_m;
    logic [LANES-1:0][WIDTH-1:0] w_vmem_m;

    assign w_acc = up.valid & r_in_rdy;
    assign w_dlv = r_main_vld & dn.ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mem_wb_lane #(.WIDTH(WIDTH)) u_lane (
            .i_en   (up.lane_mask[g]),
            .i_valu (up.valu[g]),
            .i_vmem (up.vmem[g]),
            .o_valu (w_valu_m[g]),
            .o_vmem (w_vmem_m[g])
        );
    end

    always_comb begin
        w_cap        = '0;
        w_cap.ctrl   = up.ctrl;
        w_cap.mask   = up.lane_mask;
        w_cap.valu   = w_valu_m;
        w_cap.vmem   = w_vmem_m;
        w_cap.scalar = up.scalar;
        w_cap.imm    = up.imm;
    end

    // r_in_rdy always equals !r_skid_vld; it is kept as its own flop so
    // up.ready has no combinational path from dn.ready.
    // An entry's payload is zeroed whenever it goes invalid, so the main
    // entry can drive dn.* directly and bubbles read as all-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (r_skid_vld) begin
            // up.ready is low, so no accept; drain skid into main on delivery
            if (w_dlv) begin
                r_main     <= r_skid;
                r_skid_vld <= 1'b0;
                r_skid     <= '0;
                r_in_rdy   <= 1'b1;
            end
        end else if (!r_main_vld || w_dlv) begin
            r_main_vld <= w_acc;
            r_main     <= w_acc ? w_cap : '0;
        end else if (w_acc) begin
            r_skid_vld <= 1'b1;
            r_skid     <= w_cap;
            r_in_rdy   <= 1'b0;
        end
    end

    // Stall counter ignores flush; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (r_main_vld && !dn.ready && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign up.ready     = r_in_rdy;
    assign dn.valid     = r_main_vld;
    assign dn.ctrl      = r_main.ctrl;
    assign dn.lane_mask = r_main.mask;
    assign dn.valu      = r_main.valu;
    assign dn.vmem      = r_main.vmem;
    assign dn.scalar    = r_main.scalar;
    assign dn.imm       = r_main.imm;
    assign stall_cnt    = r_stall;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed bench for mem_wb_stage (CNT_W=4 so saturation is reachable).
module tb_mem_wb_stage;
    localparam int LANES  = 4;
    localparam int WIDTH  = 32;
    localparam int CTRL_W = 5;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_stage_if #(.LANES(LANES), .WIDTH(WIDTH), .CTRL_W(CTRL_W)) up_if ();
    mem_wb_stage_if #(.LANES(LANES), .WIDTH(WIDTH), .CTRL_W(CTRL_W)) dn_if ();

    mem_wb_stage #(.LANES(LANES), .WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] s);
        up_if.valid     = v;
        up_if.scalar    = s;
        up_if.imm       = s ^ 32'hFFFF_0000;
        up_if.ctrl      = v ? 5'h1F : 5'h00;
        up_if.lane_mask = 4'hF;
        up_if.valu      = {4{s}};
        up_if.vmem      = {4{~s}};
    endtask

    task automatic do_reset();
        drive(1'b0, '0);
        flush          = 1'b0;
        dn_if.ready    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (dn_if.valid !== 1'b0 || dn_if.scalar !== '0 || dn_if.ctrl !== '0 ||
            dn_if.valu !== '0 || dn_if.lane_mask !== '0)
            begin n_fail++; $display("FAIL reset_out: valid=%b scalar=%h ctrl=%h, want all 0", dn_if.valid, dn_if.scalar, dn_if.ctrl); end
        n_tests++;
        if (up_if.ready !== 1'b1 || stall_cnt !== '0)
            begin n_fail++; $display("FAIL reset_rdy: in_ready=%b stall=%0d, want 1/0", up_if.ready, stall_cnt); end
    endtask

    task automatic test_streaming();
        do_reset();
        dn_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i);
            tick();
            n_tests++;
            if (dn_if.valid !== 1'b1 || dn_if.scalar !== i || up_if.ready !== 1'b1)
                begin n_fail++; $display("FAIL stream_%0d: valid=%b scalar=%0d rdy=%b, want 1/%0d/1", i, dn_if.valid, dn_if.scalar, up_if.ready, i); end
        end
        drive(1'b0, '0);
        tick();
        n_tests++;
        if (dn_if.valid !== 1'b0 || stall_cnt !== 0)
            begin n_fail++; $display("FAIL stream_end: valid=%b stall=%0d, want 0/0", dn_if.valid, stall_cnt); end
    endtask

    task automatic test_skid();
        do_reset();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'hA);
        tick();                       // A -> main
        n_tests++;
        if (up_if.ready !== 1'b1 || dn_if.scalar !== 32'hA)
            begin n_fail++; $display("FAIL skid_a: rdy=%b scalar=%h, want 1/a", up_if.ready, dn_if.scalar); end
        drive(1'b1, 32'hB);
        tick();                       // B -> skid, first stall edge
        drive(1'b0, '0);
        n_tests++;
        if (up_if.ready !== 1'b0 || dn_if.scalar !== 32'hA || stall_cnt !== 1)
            begin n_fail++; $display("FAIL skid_full: rdy=%b scalar=%h stall=%0d, want 0/a/1", up_if.ready, dn_if.scalar, stall_cnt); end
        repeat (5) tick();
        n_tests++;
        if (stall_cnt !== 6 || dn_if.scalar !== 32'hA)
            begin n_fail++; $display("FAIL skid_stall: stall=%0d scalar=%h, want 6/a", stall_cnt, dn_if.scalar); end
        dn_if.ready = 1'b1;
        tick();                       // A delivered, B -> main
        n_tests++;
        if (dn_if.valid !== 1'b1 || dn_if.scalar !== 32'hB || up_if.ready !== 1'b1)
            begin n_fail++; $display("FAIL skid_b: valid=%b scalar=%h rdy=%b, want 1/b/1", dn_if.valid, dn_if.scalar, up_if.ready); end
        tick();                       // B delivered
        n_tests++;
        if (dn_if.valid !== 1'b0 || dn_if.scalar !== '0 || stall_cnt !== 6)
            begin n_fail++; $display("FAIL skid_drain: valid=%b scalar=%h stall=%0d, want 0/0/6", dn_if.valid, dn_if.scalar, stall_cnt); end
    endtask

    task automatic test_lane_mask();
        do_reset();
        dn_if.ready     = 1'b1;
        drive(1'b1, 32'h5);
        up_if.lane_mask = 4'b0101;
        up_if.valu      = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        up_if.vmem      = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        tick();
        drive(1'b0, '0);
        n_tests++;
        if (dn_if.valu !== {32'h0, 32'h33333333, 32'h0, 32'h11111111} || dn_if.lane_mask !== 4'b0101)
            begin n_fail++; $display("FAIL mask_valu: valu=%h mask=%b, want 0000000033333333000000001111111 1/0101", dn_if.valu, dn_if.lane_mask); end
        n_tests++;
        if (dn_if.vmem !== {32'h0, 32'hCCCCCCCC, 32'h0, 32'hAAAAAAAA} || dn_if.scalar !== 32'h5 ||
            dn_if.imm !== 32'hFFFF0005 || dn_if.ctrl !== 5'h1F)
            begin n_fail++; $display("FAIL mask_vmem: vmem=%h scalar=%h imm=%h ctrl=%h", dn_if.vmem, dn_if.scalar, dn_if.imm, dn_if.ctrl); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'hD);
        tick();                       // D -> main
        drive(1'b1, 32'hE);
        tick();                       // E -> skid, stall=1
        n_tests++;
        if (up_if.ready !== 1'b0 || stall_cnt !== 1)
            begin n_fail++; $display("FAIL flush_fill: rdy=%b stall=%0d, want 0/1", up_if.ready, stall_cnt); end
        // up.ready is low here, so force a C offer alongside flush
        drive(1'b1, 32'hC);
        flush = 1'b1;
        tick();                       // edge still had valid&!ready: stall=2
        flush = 1'b0;
        drive(1'b0, '0);
        n_tests++;
        if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 || dn_if.scalar !== '0 || up_if.ready !== 1'b1)
            begin n_fail++; $display("FAIL flush_out: valid=%b ctrl=%h scalar=%h rdy=%b, want 0/0/0/1", dn_if.valid, dn_if.ctrl, dn_if.scalar, up_if.ready); end
        n_tests++;
        if (stall_cnt !== 2)
            begin n_fail++; $display("FAIL flush_stall: stall=%0d, want 2", stall_cnt); end
        dn_if.ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (dn_if.valid !== 1'b0 || stall_cnt !== 2)
            begin n_fail++; $display("FAIL flush_after: valid=%b stall=%0d, want 0/2", dn_if.valid, stall_cnt); end
        // flush beats a simultaneous accept into an empty stage too
        drive(1'b1, 32'hC);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0);
        n_tests++;
        if (dn_if.valid !== 1'b0 || dn_if.scalar !== '0)
            begin n_fail++; $display("FAIL flush_drop: valid=%b scalar=%h, want 0/0", dn_if.valid, dn_if.scalar); end
    endtask

    task automatic test_async_reset();
        do_reset();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h77);
        tick();                       // load
        drive(1'b0, '0);
        tick();                       // one stall edge
        n_tests++;
        if (dn_if.valid !== 1'b1 || stall_cnt !== 1)
            begin n_fail++; $display("FAIL areset_pre: valid=%b stall=%0d, want 1/1", dn_if.valid, stall_cnt); end
        #2 reset = 1'b1;              // mid-cycle, no edge until +6
        #1;
        n_tests++;
        if (dn_if.valid !== 1'b0 || dn_if.scalar !== '0 || stall_cnt !== 0 || up_if.ready !== 1'b1)
            begin n_fail++; $display("FAIL areset_now: valid=%b scalar=%h stall=%0d rdy=%b, want 0/0/0/1", dn_if.valid, dn_if.scalar, stall_cnt, up_if.ready); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h99);
        tick();
        drive(1'b0, '0);
        n_tests++;
        if (dn_if.valid !== 1'b1 || dn_if.scalar !== 32'h99)
            begin n_fail++; $display("FAIL areset_post: valid=%b scalar=%h, want 1/99", dn_if.valid, dn_if.scalar); end
    endtask

    task automatic test_saturation();
        do_reset();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h3);
        tick();                       // load, no stall yet
        drive(1'b0, '0);
        repeat (14) tick();
        n_tests++;
        if (stall_cnt !== 14)
            begin n_fail++; $display("FAIL sat_14: stall=%0d, want 14", stall_cnt); end
        repeat (5) tick();            // 20 edges total
        n_tests++;
        if (stall_cnt !== 15 || dn_if.scalar !== 32'h3)
            begin n_fail++; $display("FAIL sat_15: stall=%0d scalar=%h, want 15/3", stall_cnt, dn_if.scalar); end
    endtask

    initial begin
        drive(1'b0, '0);
        dn_if.ready = 1'b0;
        test_reset();
        test_streaming();
        test_skid();
        test_lane_mask();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
